// File: rtl/rv_mem_pkg.sv
// Shared encodings for the RV32I memory arbiter and the load aligner:
// funct3 codes, FSM states, requester ownership and the registered command.
package rv_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  func3;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

endpackage

// File: rtl/rv_load_align.sv
// Combinational load-data aligner: picks the addressed byte/half from a memory
// word and sign- or zero-extends it according to the load funct3.
module rv_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_byte  = i_word[7:0];
    w_half  = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    o_rdata = i_word;
    case (i_addr_lo)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    case (i_func3)
      LB:      o_rdata = {{24{w_byte[7]}}, w_byte};
      LBU:     o_rdata = {24'd0, w_byte};
      LH:      o_rdata = {{16{w_half[15]}}, w_half};
      LHU:     o_rdata = {16'd0, w_half};
      default: o_rdata = i_word;
    endcase
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one single-port word memory between the RV32I fetch and data ports:
// burst-limited arbitration, one transaction at a time, error/timeout reporting.
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned DATA_BURST_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0]  BURST_MAX = 4'(DATA_BURST_MAX);
  localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TMO_LAST  = TMO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_t      r_state, w_next_state;
  cmd_t        r_cmd, w_cmd;
  logic        w_cmd_err;
  logic        w_idle, w_grant_i, w_grant_d, w_grant, w_tmo;
  logic [3:0]  r_burst_cnt;
  logic [15:0] r_tmo_cnt;
  logic [31:0] w_load_data;
  logic        w_resp_en, w_resp_err;
  owner_t      w_resp_owner;
  logic [31:0] w_resp_data;
  logic [31:0] r_i_rdata, r_d_rdata;
  logic        r_i_err, r_d_err;

  // Data has priority unless it has used its burst allowance while fetch waits.
  always_comb begin
    w_idle    = (r_state == IDLE) && !reset;
    w_grant_d = w_idle && d_req && !(i_req && (r_burst_cnt == BURST_MAX));
    w_grant_i = w_idle && i_req && !w_grant_d;
    w_grant   = w_grant_i || w_grant_d;
  end

  always_comb begin
    w_cmd       = '0;
    w_cmd_err   = 1'b0;
    if (w_grant_i) begin
      w_cmd.owner = OWN_I;
      w_cmd.addr  = i_addr;
      w_cmd.func3 = LW;
      w_cmd.be    = 4'b1111;
      w_cmd_err   = (i_addr[1:0] != 2'b00);
    end else begin
      w_cmd.owner = OWN_D;
      w_cmd.we    = d_we;
      w_cmd.addr  = d_addr;
      w_cmd.func3 = d_func3;
      w_cmd.be    = 4'b1111;
      if (d_we) begin
        case (d_func3)
          SB: begin
            w_cmd.be    = 4'b0001 << d_addr[1:0];
            w_cmd.wdata = {4{d_wdata[7:0]}};
          end
          SH: begin
            w_cmd.be    = d_addr[1] ? 4'b1100 : 4'b0011;
            w_cmd.wdata = {2{d_wdata[15:0]}};
            w_cmd_err   = d_addr[0];
          end
          SW: begin
            w_cmd.wdata = d_wdata;
            w_cmd_err   = (d_addr[1:0] != 2'b00);
          end
          default: w_cmd_err = 1'b1;
        endcase
      end else begin
        case (d_func3)
          LB, LBU: w_cmd_err = 1'b0;
          LH, LHU: w_cmd_err = d_addr[0];
          LW:      w_cmd_err = (d_addr[1:0] != 2'b00);
          default: w_cmd_err = 1'b1;
        endcase
      end
    end
  end

  assign w_tmo = TMO_EN && (r_tmo_cnt == TMO_LAST);

  // Rejected commands skip ISSUE; in ISSUE an ack takes precedence over the timeout.
  always_comb begin
    w_next_state = r_state;
    w_resp_en    = 1'b0;
    w_resp_owner = r_cmd.owner;
    w_resp_data  = '0;
    w_resp_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          if (w_cmd_err) begin
            w_next_state = RESP;
            w_resp_en    = 1'b1;
            w_resp_owner = w_cmd.owner;
            w_resp_err   = 1'b1;
          end else begin
            w_next_state = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (m_ack) begin
          w_next_state = RESP;
          w_resp_en    = 1'b1;
          w_resp_data  = r_cmd.we ? 32'd0 : w_load_data;
        end else if (w_tmo) begin
          w_next_state = RESP;
          w_resp_en    = 1'b1;
          w_resp_err   = 1'b1;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cmd       <= '0;
      r_burst_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_i_rdata   <= '0;
      r_i_err     <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_cmd     <= w_cmd;
        r_tmo_cnt <= '0;
        if (w_grant_d && i_req) begin
          if (r_burst_cnt != BURST_MAX) r_burst_cnt <= r_burst_cnt + 4'd1;
        end else begin
          r_burst_cnt <= '0;
        end
      end else if (r_state == ISSUE) begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
      if (w_resp_en) begin
        if (w_resp_owner == OWN_I) begin
          r_i_rdata <= w_resp_data;
          r_i_err   <= w_resp_err;
        end else begin
          r_d_rdata <= w_resp_data;
          r_d_err   <= w_resp_err;
        end
      end
    end
  end

  rv_load_align u_load_align (
    .i_word    (m_rdata),
    .i_addr_lo (r_cmd.addr[1:0]),
    .i_func3   (r_cmd.func3),
    .o_rdata   (w_load_data)
  );

  assign i_ready  = w_grant_i;
  assign d_ready  = w_grant_d;
  assign i_rvalid = (r_state == RESP) && (r_cmd.owner == OWN_I);
  assign d_rvalid = (r_state == RESP) && (r_cmd.owner == OWN_D);
  assign i_rdata  = r_i_rdata;
  assign i_err    = r_i_err;
  assign d_rdata  = r_d_rdata;
  assign d_err    = r_d_err;
  assign m_req    = (r_state == ISSUE);
  assign m_we     = r_cmd.we;
  assign m_addr   = {r_cmd.addr[31:2], 2'b00};
  assign m_be     = r_cmd.be;
  assign m_wdata  = r_cmd.wdata;

endmodule
